// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge
//   Memory-mapped responder for the CPU 0x8xxx_xxxx I/O region. It places a TX
//   FIFO and an RX FIFO between the CPU load/store stage and the UART
//   ready/valid handshakes. It also provides status, sticky error and
//   free-running cycle-counter registers.
//
//   Register map (addr[4:0]):
//     0x00 RO  {30'b0, rx_nonempty, tx_notfull}
//     0x04 RO  RX head byte; a read pops RX when it is non-empty, else reads 0
//     0x08 WO  wmask[0] pushes wdata[7:0] into TX; a push while full sets tx_ovf
//     0x0C RW  {22'b0, rx_ovf, tx_ovf, rx_count[3:0], tx_count[3:0]}; any write clears
//     0x10 RO  cycle counter
//     0x18 WO  any write zeroes the cycle counter
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   addr, wdata, wmask   CPU request address, lane-shifted store data, byte enables
//   req_rd, req_wr       load / store request strobes (store wins when both are set)
//   rdata                registered load response, one cycle after req_rd
//   tx_data/valid/ready  byte stream to the UART transmitter
//   rx_data/valid/ready  byte stream from the UART receiver
module uart_mmio_bridge #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        req_rd,
    input  logic        req_wr,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam logic [4:0] OFF_STATUS = 5'h00;
    localparam logic [4:0] OFF_RXDATA = 5'h04;
    localparam logic [4:0] OFF_TXDATA = 5'h08;
    localparam logic [4:0] OFF_ERRCNT = 5'h0C;
    localparam logic [4:0] OFF_CYCLE  = 5'h10;
    localparam logic [4:0] OFF_CYCCLR = 5'h18;

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic       sel;
    logic       wr_en;
    logic       rd_en;
    logic [4:0] off;

    assign sel   = (addr[31:28] == 4'h8);
    assign wr_en = sel && req_wr;
    assign rd_en = sel && req_rd && !req_wr;
    assign off   = addr[4:0];

    // Address and data bits outside the decoded fields.
    logic unused_bits;
    assign unused_bits = ^{addr[27:5], wdata[31:8], wmask[3:1]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]  tx_mem [DEPTH];
    logic [AW:0] tx_wr_ptr, tx_rd_ptr, tx_count;
    logic        tx_empty, tx_full, tx_push, tx_pop, tx_push_req;

    assign tx_empty    = (tx_wr_ptr == tx_rd_ptr);
    assign tx_full     = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                         (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
    assign tx_count    = tx_wr_ptr - tx_rd_ptr;
    assign tx_push_req = wr_en && (off == OFF_TXDATA) && wmask[0];
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign tx_push     = tx_push_req && !tx_full;
    assign tx_valid    = !tx_empty;
    assign tx_pop      = tx_valid && tx_ready;
    assign tx_data     = tx_mem[tx_rd_ptr[AW-1:0]];

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr[AW-1:0]] <= wdata[7:0];
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]  rx_mem [DEPTH];
    logic [AW:0] rx_wr_ptr, rx_rd_ptr, rx_count;
    logic        rx_empty, rx_full, rx_push, rx_pop;
    logic [7:0]  rx_head;

    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                      (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
    assign rx_count = rx_wr_ptr - rx_rd_ptr;
    // Reset clears the pointers, so rx_full alone would let a byte in during rst.
    assign rx_ready = !rst && !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = rd_en && (off == OFF_RXDATA) && !rx_empty;
    assign rx_head  = rx_mem[rx_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // RX stall watchdog: the receiver has waited on a full FIFO for 2^16
    // consecutive cycles. Any break in the stall, including a push, restarts it.
    // ------------------------------------------------------------------
    logic [15:0] stall_cnt;
    logic        rx_stall, rx_ovf_set;

    assign rx_stall   = rx_valid && rx_full;
    assign rx_ovf_set = rx_stall && (stall_cnt == 16'hFFFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           stall_cnt <= '0;
        else if (rx_stall) stall_cnt <= stall_cnt + 16'd1;
        else               stall_cnt <= '0;
    end

    // ------------------------------------------------------------------
    // Sticky error bits. A new error event in the same cycle as a clear
    // is kept, so no overflow goes unreported.
    // ------------------------------------------------------------------
    logic tx_ovf, rx_ovf, sticky_clr;

    assign sticky_clr = wr_en && (off == OFF_ERRCNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (sticky_clr) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end
            if (tx_push_req && tx_full) tx_ovf <= 1'b1;
            if (rx_ovf_set)             rx_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter; a clearing write beats the increment.
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                cycle_cnt <= '0;
        else if (wr_en && (off == OFF_CYCCLR))  cycle_cnt <= '0;
        else                                    cycle_cnt <= cycle_cnt + 32'd1;
    end

    // ------------------------------------------------------------------
    // Read mux and registered response
    // ------------------------------------------------------------------
    logic [31:0] rd_value;
    logic [3:0]  tx_cnt4, rx_cnt4;

    assign tx_cnt4 = 4'(tx_count);
    assign rx_cnt4 = 4'(rx_count);

    // NOTE: rd_value gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rd_value = '0;
        case (off)
            OFF_STATUS: rd_value = {30'b0, !rx_empty, !tx_full};
            OFF_RXDATA: rd_value = rx_empty ? 32'h0 : {24'b0, rx_head};
            OFF_ERRCNT: rd_value = {22'b0, rx_ovf, tx_ovf, rx_cnt4, tx_cnt4};
            OFF_CYCLE:  rd_value = cycle_cnt;
            default:    rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata <= '0;
        else if (rd_en) rdata <= rd_value;
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge
//   Directed self-checking bench for uart_mmio_bridge (DEPTH = 8). Inputs are
//   driven on the falling edge and outputs are sampled on the falling edge,
//   half a cycle away from the active rising edge.
module tb_uart_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int n_vec = 0;
    int n_err = 0;

    uart_mmio_bridge #(.DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .wmask    (wmask),
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXDATA = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_ERRCNT = 32'h8000_000C;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
    localparam logic [31:0] A_CYCCLR = 32'h8000_0018;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One-cycle load: request on this falling edge, response at the next one.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr   = a;
        req_rd = 1'b1;
        @(negedge clk);
        req_rd = 1'b0;
        d      = rdata;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr   = a;
        wdata  = d;
        wmask  = m;
        req_wr = 1'b1;
        @(negedge clk);
        req_wr = 1'b0;
    endtask

    // Drain n TX bytes starting at first, one per cycle, then expect empty.
    task automatic drain_tx(input string tag, input logic [7:0] first, input int n);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check(tag, {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'(first + 8'(i))});
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check({tag, "_empty"}, {31'b0, tx_valid}, 32'h0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst      = 1'b1;
        addr     = '0;
        wdata    = '0;
        wmask    = '0;
        req_rd   = 1'b0;
        req_wr   = 1'b0;
        tx_ready = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
        check("rst_rdata",    rdata,             32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        @(negedge clk);
        read_check("status_after_reset", A_STATUS, 32'h1);

        // ---------------- TX fill, overflow, drain ----------------
        for (int i = 0; i < 8; i++)
            bus_write(A_TXDATA, 32'h41 + 32'(i), 4'h1);
        bus_write(A_TXDATA, 32'h49, 4'h1);
        read_check("status_tx_full", A_STATUS, 32'h0);
        read_check("errcnt_tx_ovf",  A_ERRCNT, 32'h108);
        drain_tx("tx_order", 8'h41, 8);
        bus_write(A_ERRCNT, 32'h0, 4'h0);
        read_check("errcnt_cleared", A_ERRCNT, 32'h0);

        // ---------------- RX fill, backpressure, pops ----------------
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'h10 + 8'(i);
            check("rx_ready_open", {31'b0, rx_ready}, 32'h1);
            @(negedge clk);
        end
        rx_data = 8'h18;
        check("rx_ready_full", {31'b0, rx_ready}, 32'h0);
        read_check("errcnt_rx8",   A_ERRCNT, 32'h80);
        read_check("status_rx_ne", A_STATUS, 32'h3);
        read_check("rx_pop_0", A_RXDATA, 32'h10);
        check("rx_ready_after_pop", {31'b0, rx_ready}, 32'h1);
        // This pop coincides with the ninth byte being accepted.
        read_check("rx_pop_1", A_RXDATA, 32'h11);
        rx_valid = 1'b0;
        read_check("errcnt_rx7", A_ERRCNT, 32'h70);
        for (int i = 2; i < 9; i++)
            read_check("rx_pop_n", A_RXDATA, 32'h10 + 32'(i));
        read_check("rx_pop_empty", A_RXDATA, 32'h0);
        read_check("status_rx_empty", A_STATUS, 32'h1);

        // ---------------- TX simultaneous push and pop at count 3 ----------------
        bus_write(A_TXDATA, 32'hA0, 4'h1);
        bus_write(A_TXDATA, 32'hA1, 4'h1);
        bus_write(A_TXDATA, 32'hA2, 4'h1);
        read_check("tx_count3", A_ERRCNT, 32'h3);
        tx_ready = 1'b1;
        bus_write(A_TXDATA, 32'hA3, 4'h1);
        tx_ready = 1'b0;
        read_check("tx_count3_pushpop", A_ERRCNT, 32'h3);
        drain_tx("tx_order_pushpop", 8'hA1, 3);

        // ---------------- decode corner cases ----------------
        read_check("status_idle", A_STATUS, 32'h1);
        bus_write(32'h1000_0008, 32'h55, 4'h1);
        // Store and load together: the store happens, rdata keeps its value.
        addr   = A_TXDATA;
        wdata  = 32'h77;
        wmask  = 4'h1;
        req_rd = 1'b1;
        req_wr = 1'b1;
        @(negedge clk);
        req_rd = 1'b0;
        req_wr = 1'b0;
        check("rdwr_rdata_held", rdata, 32'h1);
        bus_write(A_TXDATA, 32'h88, 4'h0);
        read_check("tx_count_decode", A_ERRCNT, 32'h1);
        check("tx_head_decode", {24'b0, tx_data}, 32'h77);
        read_check("rd_outside_held", 32'h0000_0000, 32'h1);
        read_check("rd_unmapped", 32'h8000_0014, 32'h0);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("tx_drained_decode", {31'b0, tx_valid}, 32'h0);

        // ---------------- cycle counter clear and wrap ----------------
        bus_write(A_CYCCLR, 32'h0, 4'h0);
        read_check("cyc_clr_0", A_CYCLE, 32'h0);
        read_check("cyc_clr_1", A_CYCLE, 32'h1);
        read_check("cyc_clr_2", A_CYCLE, 32'h2);
        dut.cycle_cnt = 32'hFFFF_FFFF;
        read_check("cyc_max",  A_CYCLE, 32'hFFFF_FFFF);
        read_check("cyc_wrap", A_CYCLE, 32'h0);

        // ---------------- asynchronous reset mid-transfer ----------------
        for (int i = 0; i < 9; i++)
            bus_write(A_TXDATA, 32'h61 + 32'(i), 4'h1);
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        tx_ready = 1'b0;
        read_check("errcnt_pre_rst", A_ERRCNT, 32'h105);
        check("tx_head_pre_rst", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h64});
        #2;
        rst = 1'b1;
        #1;
        check("async_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("async_rdata",    rdata,             32'h0);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        @(negedge clk);
        check("rst_rx_ready_hold", {31'b0, rx_ready}, 32'h0);
        @(negedge clk);
        rx_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        read_check("errcnt_post_rst", A_ERRCNT, 32'h0);
        read_check("status_post_rst", A_STATUS, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
